// File: rtl/conv_accum_wb.sv
// Per-pixel tap accumulator with bias, shift and saturation, and a valid/ready pixel writeback.
// Optional build macro CONV_ACCUM_RELU_EN clamps negative results to zero after saturation.
module conv_accum_wb #(
  parameter int unsigned PW    = 48,
  parameter int unsigned F     = 3,
  parameter int unsigned K     = 3,
  parameter int unsigned OUT_N = 30,
  parameter int unsigned ACC_W = 56,
  parameter int unsigned OW    = 24,
  parameter int unsigned SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 abort,
  input  logic signed [OW-1:0] bias,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [PW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_data,
  output logic [15:0]          out_row,
  output logic [15:0]          out_col,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 sat_flag
);

  localparam int unsigned Taps = F * F * K;
  localparam int unsigned TapW = $clog2(Taps);
  localparam logic signed [ACC_W-1:0] MaxV = {{(ACC_W-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MinV = {{(ACC_W-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAccum, StEmit, StDone} state_e;

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [TapW-1:0]           tap_q, tap_d;
  logic [15:0]               row_q, row_d, col_q, col_d;
  logic signed [OW-1:0]      bias_q, bias_d, out_q, out_d;
  logic                      sat_q, sat_d;

  logic signed [ACC_W-1:0]   sum, shifted;
  logic signed [OW-1:0]      res;
  logic                      clamp, last_tap, last_pix;

  assign last_tap = (tap_q == TapW'(Taps - 1));
  assign last_pix = (row_q == 16'(OUT_N - 1)) && (col_q == 16'(OUT_N - 1));
  assign sum      = acc_q + ACC_W'(in_data);
  assign shifted  = sum >>> SHIFT;

  always_comb begin
    clamp = 1'b0;
    res   = shifted[OW-1:0];
    if (shifted > MaxV) begin
      res   = MaxV[OW-1:0];
      clamp = 1'b1;
    end else if (shifted < MinV) begin
      res   = MinV[OW-1:0];
      clamp = 1'b1;
    end
`ifdef CONV_ACCUM_RELU_EN
    if (res < 0) res = '0;
`endif
  end

  // abort wins over any same-cycle handshake, so both ready and valid are masked by it
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    frame_done = 1'b0;
    busy       = (state_q != StIdle);
    unique case (state_q)
      StIdle:  if (start) state_d = StAccum;
      StAccum: begin
        in_ready = 1'b1;
        if (in_valid && last_tap) state_d = StEmit;
      end
      StEmit: begin
        out_valid = 1'b1;
        if (out_ready) state_d = last_pix ? StDone : StAccum;
      end
      StDone: begin
        frame_done = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d    = StIdle;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      frame_done = 1'b0;
    end
  end

  always_comb begin
    acc_d  = acc_q;
    tap_d  = tap_q;
    row_d  = row_q;
    col_d  = col_q;
    bias_d = bias_q;
    out_d  = out_q;
    sat_d  = sat_q;
    if (abort) begin
      acc_d = '0;
      tap_d = '0;
      row_d = '0;
      col_d = '0;
    end else begin
      unique case (state_q)
        StIdle: if (start) begin
          bias_d = bias;
          acc_d  = ACC_W'(bias);
          tap_d  = '0;
          row_d  = '0;
          col_d  = '0;
          sat_d  = 1'b0;
        end
        StAccum: if (in_valid) begin
          acc_d = sum;
          tap_d = tap_q + TapW'(1);
          if (last_tap) begin
            out_d = res;
            tap_d = '0;
            if (clamp) sat_d = 1'b1;
          end
        end
        StEmit: if (out_ready && !last_pix) begin
          acc_d = ACC_W'(bias_q);
          tap_d = '0;
          if (col_q == 16'(OUT_N - 1)) begin
            col_d = '0;
            row_d = row_q + 16'd1;
          end else begin
            col_d = col_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      acc_q   <= '0;
      tap_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      bias_q  <= '0;
      out_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      tap_q   <= tap_d;
      row_q   <= row_d;
      col_q   <= col_d;
      bias_q  <= bias_d;
      out_q   <= out_d;
      sat_q   <= sat_d;
    end
  end

  assign out_data = out_q;
  assign out_row  = row_q;
  assign out_col  = col_q;
  assign sat_flag = sat_q;

endmodule

// File: tb/tb_conv_accum_wb.sv
// Directed bench for conv_accum_wb: single pixels, full frame, saturation, stalls, abort, reset.
module tb_conv_accum_wb;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic signed [23:0]  bias = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [47:0]  in_data = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic signed [23:0]  out_data;
  logic [15:0]         out_row, out_col;
  logic                busy, frame_done, sat_flag;

  int n_checks = 0;
  int n_fail   = 0;

  conv_accum_wb dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .abort      (abort),
    .bias       (bias),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_col    (out_col),
    .busy       (busy),
    .frame_done (frame_done),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input logic signed [23:0] b);
    start = 1'b1;
    bias  = b;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // Offers n products base + i*step, each held until accepted.
  task automatic feed(input int n, input logic signed [47:0] base, input logic signed [47:0] step);
    for (int i = 0; i < n; i++) begin
      int budget = 0;
      in_valid = 1'b1;
      in_data  = base + 48'(i) * step;
      while (!in_ready && budget < 50) begin
        tick();
        budget++;
      end
      if (!in_ready) begin
        check_eq("feed_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input longint exp_data, input int r, input int c);
    int budget = 0;
    while (!out_valid && budget < 50) begin
      tick();
      budget++;
    end
    check_eq({tag, "_valid"}, longint'(out_valid), 1);
    check_eq({tag, "_data"}, longint'(out_data), exp_data);
    check_eq({tag, "_row"}, longint'(out_row), longint'(r));
    check_eq({tag, "_col"}, longint'(out_col), longint'(c));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic recv_quiet(input longint exp_data, input int r, input int c);
    int budget = 0;
    while (!out_valid && budget < 50) begin
      tick();
      budget++;
    end
    if (!out_valid || out_data !== 24'(exp_data) || out_row !== 16'(r) || out_col !== 16'(c))
      check_eq("frame_pixel", longint'(r) * 1000 + longint'(c), -1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    longint neg_sat;
    int     frame_bad;
`ifdef CONV_ACCUM_RELU_EN
    neg_sat = 0;
`else
    neg_sat = -8388608;
`endif

    repeat (3) tick();
    check_eq("rst_busy", longint'(busy), 0);
    check_eq("rst_in_ready", longint'(in_ready), 0);
    check_eq("rst_out_valid", longint'(out_valid), 0);
    check_eq("rst_out_data", longint'(out_data), 0);
    check_eq("rst_frame_done", longint'(frame_done), 0);
    check_eq("rst_sat", longint'(sat_flag), 0);
    check_eq("rst_rowcol", longint'({out_row, out_col}), 0);
    rstn = 1'b1;
    tick();

    // Basic pixel: 27 ones, no bias
    do_start(24'sd0);
    check_eq("basic_busy", longint'(busy), 1);
    check_eq("basic_in_ready", longint'(in_ready), 1);
    out_ready = 1'b1;
    feed(27, 48'sd1, 48'sd0);
    check_eq("basic_latency", longint'(out_valid), 1);
    check_eq("basic_data", longint'(out_data), 27);
    check_eq("basic_rowcol", longint'({out_row, out_col}), 0);
    tick();
    out_ready = 1'b0;
    check_eq("basic_valid_drop", longint'(out_valid), 0);
    check_eq("basic_next_col", longint'(out_col), 1);
    do_abort();
    check_eq("abort_busy", longint'(busy), 0);

    // Abort mid-pixel, then a clean pixel with no residue, then backpressure
    do_start(24'sd0);
    feed(13, 48'sd1, 48'sd0);
    do_abort();
    check_eq("abort_idle", longint'(busy), 0);
    do_start(24'sd0);
    feed(27, 48'sd1, 48'sd0);
    in_valid = 1'b1;
    in_data  = 48'sd1;
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_in_ready", longint'(in_ready), 0);
      check_eq("bp_valid", longint'(out_valid), 1);
      check_eq("bp_data", longint'(out_data), 27);
      check_eq("bp_rowcol", longint'({out_row, out_col}), 0);
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    out_ready = 1'b0;
    check_eq("bp_accepted", longint'(out_valid), 0);
    check_eq("bp_col_adv", longint'(out_col), 1);
    do_abort();

    // Start while busy is ignored
    do_start(24'sd7);
    do_start(24'sd100);
    feed(27, 48'sd1, 48'sd0);
    recv("busy_start0", 34, 0, 0);
    do_start(24'sd100);
    feed(27, 48'sd1, 48'sd0);
    recv("busy_start1", 34, 0, 1);
    do_abort();

    // Saturation both ways
    do_start(24'sd0);
    check_eq("sat_clear0", longint'(sat_flag), 0);
    feed(27, 48'sd1 <<< 40, 48'sd0);
    check_eq("sat_pos_flag", longint'(sat_flag), 1);
    recv("sat_pos", 8388607, 0, 0);
    feed(27, -(48'sd1 <<< 40), 48'sd0);
    recv("sat_neg", neg_sat, 0, 1);
    check_eq("sat_sticky", longint'(sat_flag), 1);
    do_abort();
    do_start(24'sd0);
    check_eq("sat_clear_on_start", longint'(sat_flag), 0);
    do_abort();

    // Full frame, bias 5, products 0..26 => 356 per pixel
    frame_bad = n_fail;
    do_start(24'sd5);
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 30; c++) begin
        feed(27, 48'sd0, 48'sd1);
        if (r == 29 && c == 29) recv("frame_last", 356, 29, 29);
        else if (r == 0 && c == 0) recv("frame_first", 356, 0, 0);
        else recv_quiet(356, r, c);
      end
    check_eq("frame_pixels_ok", longint'(n_fail - frame_bad), 0);
    check_eq("frame_done_pulse", longint'(frame_done), 1);
    check_eq("frame_done_busy", longint'(busy), 1);
    tick();
    check_eq("frame_done_once", longint'(frame_done), 0);
    check_eq("frame_busy_drop", longint'(busy), 0);
    check_eq("frame_sat", longint'(sat_flag), 0);

    // Reset asserted while a pixel waits in EMIT
    do_start(24'sd0);
    feed(27, 48'sd1, 48'sd0);
    check_eq("rst_emit_valid_pre", longint'(out_valid), 1);
    #2 rstn = 1'b0;
    #1;
    check_eq("rst_emit_valid", longint'(out_valid), 0);
    check_eq("rst_emit_busy", longint'(busy), 0);
    check_eq("rst_emit_data", longint'(out_data), 0);
    tick();
    rstn = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
